seven_seg_scan_decoder: RTL and testbench
=========================================

# seven_seg_scan_decoder

Recovers displayed digits from the multiplexed seven-segment display bus: samples the active-low segment lines and active-low digit enables, waits for each pattern to settle, and decodes the segment code back to a BCD digit per display position. It is the inverse of the BCD-to-segment encoder and sits on the display pins as a self-check and readback block for the stopwatch, so the result can be compared against the counters in simulation or on hardware.

## Interface
- NUM_DIGITS, 4, number of multiplexed display positions (1..8)
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture (>=1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- seg_in  in  8  segment bus, active-low; bit7 = dp, bit6..0 = g..a
- an_in  in  NUM_DIGITS  digit enables, active-low; bit i selects position i
- err_clr  in  1  clears error (synchronous, one cycle)
- digits_out  out  4*NUM_DIGITS  BCD digit i at bits [4i+3:4i]
- dp_out  out  NUM_DIGITS  decoded decimal point per position, 1 = lit
- digit_valid  out  NUM_DIGITS  position i holds a legal decoded digit
- frame_valid  out  1  one-cycle pulse: every position captured since last pulse
- error  out  1  sticky: illegal segment code or more than one enable active

## Operation
- Two-flop synchronizer on seg_in and an_in; synchronizer flops reset to all-ones (blank, no position enabled).
- Decode table on seg[6:0]: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9; any other code is illegal. dp_out bit = ~seg[7].
- Settle FSM on synchronized {an, seg}:
  - IDLE: no enable, or more than one enable active. Counter held at 0. Exactly one enable active -> SETTLING, counter = 1.
  - SETTLING: {an, seg} unchanged from previous sample -> counter increments; any change -> counter = 1 (stay in SETTLING if exactly one enable, else IDLE). Counter reaches STABLE_CYCLES -> capture, go to HELD.
  - HELD: no further capture while {an, seg} is unchanged. Any change -> SETTLING or IDLE, as above.
- Capture, position i = enabled index: legal code -> digits_out[i], dp_out[i] updated, digit_valid[i] = 1, seen[i] = 1. Illegal code -> digits_out[i] retained, digit_valid[i] = 0, error set, seen[i] unchanged.
- More than one enable active in any synchronized sample -> error set; no capture.
- All-enables-off (blanking) is legal, not an error.
- Frame: when a capture makes seen all-ones, frame_valid pulses and seen clears in the same cycle. Recapturing a position that is already seen updates its digit only.
- error: set wins over err_clr in the same cycle.
- Counter width: clog2(STABLE_CYCLES+1); it saturates in HELD and never wraps.

## Timing
- Reset values: digits_out 0, dp_out 0, digit_valid 0, frame_valid 0, error 0, seen 0, FSM IDLE.
- Latency: inputs that change before edge 0 and are held appear on digits_out/dp_out/digit_valid after edge STABLE_CYCLES+2. With the defaults, this is edge 6.
- frame_valid is high for exactly the cycle after the capturing edge, concurrent with the final digit update.
- Error latency equals capture latency for an illegal code. For multiple enables, error sets after edge 2, after synchronization.
- A pattern held for fewer than STABLE_CYCLES synchronized samples (ghosting during a scan transition) is never captured.
- Reset asserted mid-settle or mid-frame: all state is cleared immediately. After release, decoding restarts from IDLE with the synchronizers blank.

## Test plan
- Reset release; drive an_in=4'b1110, seg_in=8'hC0, held -> digits_out[3:0]=0, digit_valid=4'b0001 after edge 6; frame_valid stays 0.
- Scan positions 0..3 with codes 0xF9, 0x24 (dp lit: seg 0x24), 0xB0, 0x90, each held 8 cycles -> digits_out=16'h9321, dp_out=4'b0010, one frame_valid pulse coinciding with the position-3 capture.
- Position 0 with 0x92 held 3 cycles, then 0x82 held 10 cycles -> digit 0 becomes 6, never 5.
- Position 2 with illegal 0xFF (blank) held -> error=1, digit_valid[2]=0, digits_out[11:8] unchanged; err_clr pulse -> error=0.
- an_in=4'b1100 for 3 cycles -> error=1 after edge 2, no capture. err_clr asserted in the same cycle as a new error-set -> error stays 1.
- rst pulsed while position 1 is settling on 0xA4 -> all outputs 0; after release, the full 4-position scan yields frame_valid only after all four positions are recaptured.

Source files
------------

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder
//
// Reads back a multiplexed seven-segment display bus and recovers the BCD
// digit and decimal point shown at each display position. The segment and
// enable lines are synchronized first. A pattern is captured only after it
// has been seen unchanged for STABLE_CYCLES synchronized samples, so scan
// transition ghosting is ignored.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   seg_in       segment bus, active-low; bit7 = dp, bit6..0 = g..a
//   an_in        digit enables, active-low; bit i selects position i
//   err_clr      synchronous error clear (set has priority)
//   digits_out   BCD digit i at bits [4i+3:4i]
//   dp_out       decoded decimal point per position, 1 = lit
//   digit_valid  position i holds a legal decoded digit
//   frame_valid  one-cycle pulse once every position has been captured
//   error        sticky: illegal segment code or multiple enables seen
module seven_seg_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_valid,
  output logic                    error
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntStable = CntW'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettling, StHeld} state_e;

  // Two-flop synchronizers; reset to blank with no position enabled.
  logic [7:0]            seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an_in;
      an_s2_q  <= an_s1_q;
    end
  end

  // State and previous-sample registers.
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            pat_seg_q;
  logic [NUM_DIGITS-1:0] pat_an_q;

  // Output-side registers.
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  // Enable count of the current synchronized sample.
  logic [3:0] en_cnt;
  logic       one_hot;
  logic       multi_en;
  logic       changed;

  always_comb begin
    en_cnt = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      en_cnt = en_cnt + {3'b000, ~an_s2_q[i]};
    end
  end

  assign one_hot  = (en_cnt == 4'd1);
  assign multi_en = (en_cnt > 4'd1);
  assign changed  = ({an_s2_q, seg_s2_q} != {pat_an_q, pat_seg_q});

  // Settle FSM. Capture fires on the edge after the counter has reached
  // STABLE_CYCLES, using the stored pattern that produced that count.
  logic capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (one_hot) begin
          state_d = StSettling;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      StSettling: begin
        capture = (cnt_q == CntStable);
        if (changed) begin
          state_d = one_hot ? StSettling : StIdle;
          cnt_d   = one_hot ? CntW'(1) : '0;
        end else if (cnt_q == CntStable) begin
          // Counter stays saturated while the pattern is held.
          state_d = StHeld;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      StHeld: begin
        if (changed) begin
          state_d = one_hot ? StSettling : StIdle;
          cnt_d   = one_hot ? CntW'(1) : '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Segment-code decode of the stored pattern.
  logic       dec_legal;
  logic [3:0] dec_val;

  always_comb begin
    dec_legal = 1'b1;
    dec_val   = 4'd0;
    case (pat_seg_q[6:0])
      7'h40:   dec_val = 4'd0;
      7'h79:   dec_val = 4'd1;
      7'h24:   dec_val = 4'd2;
      7'h30:   dec_val = 4'd3;
      7'h19:   dec_val = 4'd4;
      7'h12:   dec_val = 4'd5;
      7'h02:   dec_val = 4'd6;
      7'h78:   dec_val = 4'd7;
      7'h00:   dec_val = 4'd8;
      7'h10:   dec_val = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  // Capture datapath. The stored pattern is one-hot whenever capture fires,
  // so the inverted enables directly select the position.
  logic [NUM_DIGITS-1:0] cap_oh;
  logic [NUM_DIGITS-1:0] seen_next;
  logic                  err_set;

  assign cap_oh = ~pat_an_q;

  always_comb begin
    digits_d  = digits_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    seen_next = seen_q;
    frame_d   = 1'b0;
    err_set   = multi_en;
    if (capture) begin
      if (dec_legal) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (cap_oh[i]) begin
            digits_d[4*i +: 4] = dec_val;
            dp_d[i]            = ~pat_seg_q[7];
          end
        end
        valid_d   = valid_q | cap_oh;
        seen_next = seen_q | cap_oh;
        if (&seen_next) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end else begin
          seen_d  = seen_next;
        end
      end else begin
        valid_d = valid_q & ~cap_oh;
        err_set = 1'b1;
      end
    end
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pat_seg_q <= '1;
      pat_an_q  <= '1;
      digits_q  <= '0;
      dp_q      <= '0;
      valid_q   <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_seg_q <= seg_s2_q;
      pat_an_q  <= an_s2_q;
      digits_q  <= digits_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
    end
  end

  assign digits_out  = digits_q;
  assign dp_out      = dp_q;
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign error       = err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed steps followed by randomized
// scan traffic, all checked against a run-length reference model.
module tb_seven_seg_scan_decoder;

  localparam int ND = 4;
  localparam int S  = 4;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic [7:0]    seg_in  = 8'hFF;
  logic [ND-1:0] an_in   = '1;
  logic          err_clr = 1'b0;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0]   dp_out;
  logic [ND-1:0]   digit_valid;
  logic            frame_valid;
  logic            error;

  seven_seg_scan_decoder #(
    .NUM_DIGITS   (ND),
    .STABLE_CYCLES(S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .err_clr    (err_clr),
    .digits_out (digits_out),
    .dp_out     (dp_out),
    .digit_valid(digit_valid),
    .frame_valid(frame_valid),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int frame_cnt = 0;
  logic [15:0] frame_digits = '0;

  // Reference model state: pins seen at the last two edges, the last
  // synchronized sample and how many samples in a row it has repeated.
  logic [11:0] m_d1, m_d2, m_prev;
  int          m_run;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_dp, m_valid, m_seen;
  logic        m_frame, m_err;

  function automatic int decode(input logic [6:0] s);
    case (s)
      7'h40: return 0;
      7'h79: return 1;
      7'h24: return 2;
      7'h30: return 3;
      7'h19: return 4;
      7'h12: return 5;
      7'h02: return 6;
      7'h78: return 7;
      7'h00: return 8;
      7'h10: return 9;
      default: return -1;
    endcase
  endfunction

  function automatic int n_enabled(input logic [3:0] an);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_d1 = 12'hFFF; m_d2 = 12'hFFF; m_prev = 12'hFFF; m_run = 1;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    m_dp = '0; m_valid = '0; m_seen = '0; m_frame = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] an, input logic [7:0] seg, input logic clr);
    logic [11:0] sample;
    logic        set_err;
    int          pos, val;
    sample  = m_d2;
    m_d2    = m_d1;
    m_d1    = {an, seg};
    set_err = 1'b0;
    m_frame = 1'b0;
    // A pattern that has just completed S identical one-hot samples is captured.
    if (m_run == S && n_enabled(m_prev[11:8]) == 1) begin
      pos = 0;
      for (int i = 0; i < 4; i++) if (!m_prev[8+i]) pos = i;
      val = decode(m_prev[6:0]);
      if (val >= 0) begin
        m_dig[pos]   = 4'(val);
        m_dp[pos]    = ~m_prev[7];
        m_valid[pos] = 1'b1;
        m_seen[pos]  = 1'b1;
        if (m_seen == 4'hF) begin
          m_frame = 1'b1;
          m_seen  = '0;
        end
      end else begin
        m_valid[pos] = 1'b0;
        set_err      = 1'b1;
      end
    end
    if (sample == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev = sample;
    if (n_enabled(sample[11:8]) > 1) set_err = 1'b1;
    if (set_err) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("digits", 32'(digits_out), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
    chk("dp", 32'(dp_out), 32'(m_dp));
    chk("valid", 32'(digit_valid), 32'(m_valid));
    chk("frame", 32'(frame_valid), 32'(m_frame));
    chk("error", 32'(error), 32'(m_err));
    if (frame_valid === 1'b1) begin
      frame_cnt++;
      frame_digits = digits_out;
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, update model, compare.
  task automatic tick(input logic [3:0] an, input logic [7:0] seg, input logic clr);
    an_in = an; seg_in = seg; err_clr = clr;
    @(posedge clk);
    model_edge(an, seg, clr);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
    for (int k = 0; k < n; k++) tick(an, seg, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1; an_in = '1; seg_in = '1; err_clr = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_digits", 32'(digits_out), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] r_an;
    logic [7:0] r_seg;
    logic [7:0] codes [10];
    codes[0] = 8'h40; codes[1] = 8'h79; codes[2] = 8'h24; codes[3] = 8'h30;
    codes[4] = 8'h19; codes[5] = 8'h12; codes[6] = 8'h02; codes[7] = 8'h78;
    codes[8] = 8'h00; codes[9] = 8'h10;
    model_reset();

    // Reset state and first-capture latency.
    do_reset();
    chk("reset_dp", 32'(dp_out), 32'h0);
    chk("reset_frame", 32'(frame_valid), 32'h0);
    frame_cnt = 0;
    hold(4'b1110, 8'hC0, 6);
    chk("lat_before_edge6", 32'(digit_valid), 32'h0);
    tick(4'b1110, 8'hC0, 1'b0);
    chk("lat_at_edge6", 32'(digit_valid), 32'h1);
    chk("lat_digit0", 32'(digits_out[3:0]), 32'h0);
    hold(4'b1110, 8'hC0, 4);
    chk("lat_no_frame", 32'(frame_cnt), 32'd0);

    // Full scan of four positions.
    frame_cnt = 0;
    hold(4'b1110, 8'hF9, 8);
    hold(4'b1101, 8'h24, 8);
    hold(4'b1011, 8'hB0, 8);
    hold(4'b0111, 8'h90, 8);
    chk("scan_digits", 32'(digits_out), 32'h9321);
    chk("scan_dp", 32'(dp_out), 32'b0010);
    chk("scan_valid", 32'(digit_valid), 32'hF);
    chk("scan_frames", 32'(frame_cnt), 32'd1);
    chk("scan_frame_digits", 32'(frame_digits), 32'h9321);

    // Ghost pattern shorter than the settle window is ignored.
    hold(4'b1110, 8'h92, 3);
    for (int k = 0; k < 10; k++) begin
      tick(4'b1110, 8'h82, 1'b0);
      chk("ghost_not5", 32'(digits_out[3:0] == 4'd5), 32'd0);
    end
    chk("ghost_digit0", 32'(digits_out[3:0]), 32'd6);

    // Illegal code on position 2, then clear.
    hold(4'b1011, 8'hFF, 10);
    chk("illegal_err", 32'(error), 32'd1);
    chk("illegal_valid2", 32'(digit_valid[2]), 32'd0);
    chk("illegal_digit2", 32'(digits_out[11:8]), 32'd3);
    tick(4'b1011, 8'hFF, 1'b1);
    chk("clr_err", 32'(error), 32'd0);
    hold(4'b1111, 8'hFF, 3);

    // Two enables at once; set beats a simultaneous clear.
    tick(4'b1100, 8'hC0, 1'b0);
    chk("multi_e0", 32'(error), 32'd0);
    tick(4'b1100, 8'hC0, 1'b0);
    chk("multi_e1", 32'(error), 32'd0);
    tick(4'b1100, 8'hC0, 1'b0);
    chk("multi_e2", 32'(error), 32'd1);
    tick(4'b1111, 8'hFF, 1'b1);
    chk("multi_set_wins", 32'(error), 32'd1);
    tick(4'b1111, 8'hFF, 1'b1);
    tick(4'b1111, 8'hFF, 1'b1);
    chk("multi_clr", 32'(error), 32'd0);
    chk("multi_no_capture", 32'(digit_valid), 32'b1011);

    // Reset in the middle of settling, then a full frame is needed again.
    hold(4'b1101, 8'hA4, 4);
    do_reset();
    frame_cnt = 0;
    hold(4'b1110, 8'hF9, 8);
    hold(4'b1101, 8'h24, 8);
    hold(4'b1011, 8'hB0, 8);
    chk("rst_no_early_frame", 32'(frame_cnt), 32'd0);
    hold(4'b0111, 8'h90, 8);
    chk("rst_frame_after_all", 32'(frame_cnt), 32'd1);

    // Randomized scan traffic.
    for (int n = 0; n < 200; n++) begin
      int sel, len;
      if (n == 100) do_reset();
      sel = int'($urandom_range(0, 99));
      if (sel < 8) begin
        do r_an = 4'($urandom); while (n_enabled(r_an) < 2);
      end else if (sel < 15) begin
        r_an = 4'hF;
      end else begin
        r_an = ~(4'b0001 << $urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) == 0) begin
        r_seg = 8'($urandom);
      end else begin
        r_seg = codes[$urandom_range(0, 9)];
        r_seg[7] = 1'($urandom);
      end
      len = int'($urandom_range(1, 9));
      for (int k = 0; k < len; k++) tick(r_an, r_seg, ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
